// File: rtl/toggle_period_meter_pkg.sv
// Shared definitions for the toggle period meter: width helper and FSM state encoding.
package toggle_period_meter_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StArm  = 2'd1,
    StMeas = 2'd2
  } meter_state_e;

  // Smallest r such that 2**r >= n.
  function automatic int unsigned ceil_log2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage

// File: rtl/toggle_period_meter_sync.sv
// Synchronizes an asynchronous strobe and produces single-cycle rise/fall indications.
module sync_edge_detect #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic d_async,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   level_d_q;

  // Synchronizer chain plus one delayed copy of the synchronized level.
  always_ff @(posedge clk) begin
    if (!reset) begin
      sync_q    <= '0;
      level_d_q <= 1'b0;
    end else begin
      sync_q    <= {sync_q[SYNC_STAGES-2:0], d_async};
      level_d_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Edge indications compare the current and previous synchronized level.
  always_comb begin
    level = sync_q[SYNC_STAGES-1];
    rise  = level & ~level_d_q;
    fall  = ~level & level_d_q;
  end

endmodule

// File: rtl/toggle_period_meter.sv
// Measures rise-to-rise period and rise-to-fall high time of a slow toggling input.
module toggle_period_meter
  import toggle_period_meter_pkg::*;
#(
  parameter int unsigned MAX_COUNT   = 1024,
  parameter int unsigned NBITS       = ceil_log2(MAX_COUNT) + 1,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  input  logic             sig_in,
  output logic [NBITS-1:0] period,
  output logic [NBITS-1:0] high_time,
  output logic             valid,
  output logic             overflow
);

  localparam logic [NBITS-1:0] MaxCnt = NBITS'(MAX_COUNT);
  localparam logic [NBITS-1:0] One    = NBITS'(1);

  meter_state_e     state_q, state_d;
  logic [NBITS-1:0] cnt_q, cnt_d;
  logic [NBITS-1:0] period_q, period_d;
  logic [NBITS-1:0] high_q, high_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  logic [NBITS-1:0] cnt_inc;

  logic sig_level;
  logic sig_rise;
  logic sig_fall;

  sync_edge_detect #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .clk    (clk),
    .reset  (reset),
    .d_async(sig_in),
    .level  (sig_level),
    .rise   (sig_rise),
    .fall   (sig_fall)
  );

  // Next-state logic; priority is enable=0 > rise > timeout > fall.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    period_d = period_q;
    high_d   = high_q;
    valid_d  = 1'b0;
    ovf_d    = ovf_q;
    cnt_inc  = cnt_q + One;

    if (!enable) begin
      state_d = StIdle;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          cnt_d   = '0;
          state_d = StArm;
        end
        StArm: begin
          // A level already high on entry is not a rise, so wait for a real edge.
          cnt_d = '0;
          if (sig_rise) begin
            state_d = StMeas;
          end
        end
        StMeas: begin
          if (sig_rise) begin
            // A rise on the timeout cycle still counts, giving period == MAX_COUNT.
            period_d = cnt_inc;
            cnt_d    = '0;
            valid_d  = 1'b1;
            ovf_d    = 1'b0;
          end else if (cnt_inc == MaxCnt) begin
            ovf_d   = 1'b1;
            cnt_d   = '0;
            state_d = StArm;
          end else begin
            cnt_d = cnt_inc;
            if (sig_fall) begin
              high_d = cnt_inc;
            end
          end
        end
        default: begin
          state_d = StIdle;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // State, counter and result registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      period_q <= '0;
      high_q   <= '0;
      valid_q  <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      high_q   <= high_d;
      valid_q  <= valid_d;
      ovf_q    <= ovf_d;
    end
  end

  // Results are driven straight from their registers.
  always_comb begin
    period    = period_q;
    high_time = high_q;
    valid     = valid_q;
    overflow  = ovf_q;
  end

endmodule
